reg_pipe_sync: RTL and testbench

//  - Parametrised chain of DEPTH data registers with valid/ready handshake and bubble collapse.
//  - Generalises the single sync-reset D flip-flop to WIDTH bits, DEPTH stages and back-pressure.
//  - Inserts between datapath blocks in lab designs to add latency or timing slack without losing words.

---
 rtl/reg_pipe_pkg.sv | 11 +
 rtl/reg_pipe_stage.sv | 32 +++
 rtl/reg_pipe_sync.sv | 91 +++++++++
 tb/tb_reg_pipe_sync.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_pipe_pkg.sv
// Shared constants and helpers for the reg_pipe register chain.
// Optional flush support is enabled by defining REG_PIPE_FLUSH_EN.
package reg_pipe_pkg;

    localparam logic RST_ACTIVE = 1'b0;

    function automatic int OCC_W(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One valid+data register of the chain; the data word only moves
// when a real word arrives, so bubbles leave the old data in place.
module reg_pipe_stage
    import reg_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             load,
    input  logic             clear,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge Clock) begin
        if (Reset == RST_ACTIVE) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= valid_in;
            if (valid_in) begin
                data <= data_in;
            end
        end
    end

endmodule

// File: rtl/reg_pipe_sync.sv
// DEPTH-stage valid/ready register chain with bubble collapse.
// Define REG_PIPE_FLUSH_EN to add the synchronous Flush input.
module reg_pipe_sync
    import reg_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic                     Clock,
    input  logic                     Reset,
`ifdef REG_PIPE_FLUSH_EN
    input  logic                     Flush,
`endif
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [OCC_W(DEPTH)-1:0]  occupancy
);

    localparam int OW = OCC_W(DEPTH);

    logic [DEPTH-1:0] stage_valid;
    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [DEPTH-1:0] adv;
    logic             flush;
    logic             in_fire;
    logic             out_fire;

`ifdef REG_PIPE_FLUSH_EN
    assign flush = Flush;
`else
    assign flush = 1'b0;
`endif

    // A stage may advance if anything downstream of it can make room.
    always_comb begin
        logic run;
        run = out_ready;
        adv = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            run    = run | ~stage_valid[i];
            adv[i] = run;
        end
    end

    assign in_ready  = adv[0] & ~flush;
    assign out_valid = stage_valid[DEPTH-1];
    assign out_data  = stage_data[DEPTH-1];
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             src_valid;
        logic [WIDTH-1:0] src_data;

        if (i == 0) begin : g_head
            assign src_valid = in_valid;
            assign src_data  = in_data;
        end else begin : g_body
            assign src_valid = stage_valid[i-1];
            assign src_data  = stage_data[i-1];
        end

        reg_pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .Clock    (Clock),
            .Reset    (Reset),
            .load     (adv[i]),
            .clear    (flush),
            .valid_in (src_valid),
            .data_in  (src_data),
            .valid    (stage_valid[i]),
            .data     (stage_data[i])
        );
    end

    always_ff @(posedge Clock) begin
        if (Reset == RST_ACTIVE) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else begin
            occupancy <= occupancy + OW'(in_fire) - OW'(out_fire);
        end
    end

endmodule

// File: tb/tb_reg_pipe_sync.sv
// Scoreboard bench for reg_pipe_sync: directed scenarios plus random traffic.
// Flush scenarios are compiled in when REG_PIPE_FLUSH_EN is defined.
module tb_reg_pipe_sync;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
    localparam int OW    = $clog2(DEPTH + 1);

    logic             Clock = 1'b0;
    logic             Reset;
    logic             flush_s;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [OW-1:0]    occupancy;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] exp_q [$];

    always #5 Clock = ~Clock;

    reg_pipe_sync #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
`ifdef REG_PIPE_FLUSH_EN
        .Flush     (flush_s),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference: a FIFO of accepted words with capacity DEPTH. The chain
    // can take a word whenever it is not full or the head is leaving.
    always @(negedge Clock) begin
        if (Reset == 1'b0) begin
            exp_q.delete();
        end else begin
            check("occupancy", 32'(occupancy), 32'(exp_q.size()));
            check("in_ready", 32'(in_ready),
                  32'(((exp_q.size() < DEPTH) || out_ready) && !flush_s));
            if (exp_q.size() == 0)
                check("idle_out_valid", 32'(out_valid), 32'(0));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    check("out_data", 32'(out_data),
                          32'(exp_q.pop_front()));
                end
            end
            if (flush_s)
                exp_q.delete();
            else if (in_valid && in_ready)
                exp_q.push_back(in_data);
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            tick();
        end
        check("drain_done", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        Reset     = 1'b0;
        flush_s   = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        out_ready = 1'b0;

        // reset held for two edges with a word offered
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_occupancy", 32'(occupancy), 32'(0));
        Reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'(1));

        // streaming, latency DEPTH-1 edges after accept
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        tick();
        in_data = 8'h22;
        tick();
        in_data = 8'h33;
        tick();
        in_valid = 1'b0;
        check("stream_v0", 32'(out_valid), 32'(1));
        check("stream_d0", 32'(out_data), 32'h11);
        check("stream_peak", 32'(occupancy), 32'(3));
        tick();
        check("stream_d1", 32'(out_data), 32'h22);
        tick();
        check("stream_d2", 32'(out_data), 32'h33);
        tick();
        check("stream_empty", 32'(out_valid), 32'(0));

        // fill under stall
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hA0 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        check("fill_occ", 32'(occupancy), 32'(3));
        check("fill_ready", 32'(in_ready), 32'(0));
        check("fill_head", 32'(out_data), 32'hA0);
        drain();

        // bubble collapse
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h01;
        tick();
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1;
        in_data  = 8'h02;
        tick();
        in_valid = 1'b0;
        tick();
        check("bubble_occ", 32'(occupancy), 32'(2));
        check("bubble_ready", 32'(in_ready), 32'(1));
        check("bubble_head", 32'(out_data), 32'h01);
        drain();

        // simultaneous in/out at full
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hB0 + 8'(i);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'hC0 + 8'(i);
            tick();
            check("full_occ", 32'(occupancy), 32'(3));
        end
        drain();

`ifdef REG_PIPE_FLUSH_EN
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hD0 + 8'(i);
            tick();
        end
        in_data = 8'hEE;
        flush_s = 1'b1;
        tick();
        flush_s  = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", 32'(out_valid), 32'(0));
        check("flush_occ", 32'(occupancy), 32'(0));

        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hE0 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        Reset    = 1'b0;
        flush_s  = 1'b1;
        tick();
        Reset   = 1'b1;
        flush_s = 1'b0;
        check("rstflush_valid", 32'(out_valid), 32'(0));
        check("rstflush_data", 32'(out_data), 32'(0));
        check("rstflush_occ", 32'(occupancy), 32'(0));
        drain();
`endif

        // random traffic with occasional reset and flush
        for (int i = 0; i < 500; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            Reset     = ($urandom_range(0, 79) != 0);
`ifdef REG_PIPE_FLUSH_EN
            flush_s   = ($urandom_range(0, 39) == 0);
`endif
            tick();
        end
        Reset   = 1'b1;
        flush_s = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
